// File: rtl/synth_pkg.sv
// synth_pkg: shared sizes, key index type and mix FSM states for the voice scheduler.
package synth_pkg;
    localparam int NUM_KEYS   = 13;
    localparam int NUM_VOICES = 3;
    localparam int SAMPLE_W   = 8;
    localparam int OUT_W      = 12;
    localparam int DIV3_MULT  = 683;
    localparam int DIV3_SHIFT = 11;

    typedef logic [3:0] key_idx_t;
    typedef enum logic [1:0] {IDLE, ACCUM, DIVIDE, DONE} mix_state_t;
endpackage

// File: rtl/voice_scheduler_if.sv
// voice_scheduler_if: key/sample inputs and mixed-sample outputs of the voice scheduler.
interface voice_scheduler_if;
    import synth_pkg::*;
    logic [NUM_KEYS-1:0]          keys_i;
    logic [NUM_KEYS*SAMPLE_W-1:0] samples_i;
    logic                         sample_tick_i;
    logic [NUM_VOICES*4-1:0]      voice_key_o;
    logic [NUM_VOICES-1:0]        voice_active_o;
    logic [OUT_W-1:0]             mixed_sample_o;
    logic                         mixed_valid_o;
    logic                         busy_o;
    logic                         overrun_o;

    modport master (
        output keys_i, samples_i, sample_tick_i,
        input  voice_key_o, voice_active_o, mixed_sample_o, mixed_valid_o, busy_o, overrun_o
    );
    modport slave (
        input  keys_i, samples_i, sample_tick_i,
        output voice_key_o, voice_active_o, mixed_sample_o, mixed_valid_o, busy_o, overrun_o
    );
endinterface

// File: rtl/voice_scheduler_voice_table.sv
// voice_table: key edge detect, pending queue, voice allocation with oldest-voice stealing.
module voice_table
    import synth_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_KEYS-1:0]     keys,
    output logic [NUM_VOICES*4-1:0] voice_key,
    output logic [NUM_VOICES-1:0]   voice_active
);
    logic [NUM_KEYS-1:0]   keys_q, pending_q, press, release_k, owned, cand, alloc_mask;
    logic [NUM_VOICES-1:0] active_q;
    key_idx_t              key_q [NUM_VOICES];
    logic [1:0]            age_q [NUM_VOICES];
    key_idx_t              alloc_key;
    logic                  alloc, any_free;
    logic [1:0]            tgt, tgt_rank;

    always_comb begin
        press = keys & ~keys_q;
        release_k = ~keys & keys_q;
        owned = '0;
        for (int v = 0; v < NUM_VOICES; v++) if (active_q[v]) owned[key_q[v]] = 1'b1;
        cand = (pending_q | press) & ~release_k & ~owned;
        alloc = |cand;
        alloc_key = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) if (cand[k]) alloc_key = key_idx_t'(k);
        alloc_mask = '0;
        alloc_mask[alloc_key] = alloc;
        any_free = 1'b0;
        tgt = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) if (!active_q[v]) begin
            any_free = 1'b1;
            tgt = 2'(v);
        end
        // Steal the highest rank; ties go to the lowest voice index.
        if (!any_free) for (int v = 1; v < NUM_VOICES; v++) if (age_q[v] > age_q[tgt]) tgt = 2'(v);
        // A free slot behaves as the oldest rank, so every active voice ages by one.
        tgt_rank = any_free ? 2'(NUM_VOICES - 1) : age_q[tgt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            keys_q    <= '0;
            pending_q <= '0;
            active_q  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                key_q[v] <= '0;
                age_q[v] <= '0;
            end
        end else begin
            keys_q    <= keys;
            pending_q <= (pending_q | press) & ~release_k & ~alloc_mask;
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && release_k[key_q[v]]) active_q[v] <= 1'b0;
                if (alloc && 2'(v) == tgt) begin
                    active_q[v] <= 1'b1;
                    key_q[v]    <= alloc_key;
                    age_q[v]    <= '0;
                end else if (alloc && active_q[v] && age_q[v] < tgt_rank) begin
                    age_q[v] <= age_q[v] + 2'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) assign voice_key[g*4 +: 4] = key_q[g];
    assign voice_active = active_q;
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: polyphony controller; mixes assigned voices into one normalized sample per tick.
module voice_scheduler
    import synth_pkg::*;
(
    input logic         clk,
    input logic         rst,
    voice_scheduler_if.slave bus
);
    mix_state_t              state, state_n;
    logic [NUM_VOICES*4-1:0] voice_key, snap_key;
    logic [NUM_VOICES-1:0]   voice_active, snap_act;
    logic [1:0]              vi, cnt;
    logic [9:0]              acc;
    logic [19:0]             prod;
    logic [SAMPLE_W-1:0]     cur, avg;
    logic [OUT_W-1:0]        mixed_q;
    logic                    overrun_q;

    voice_table u_table (
        .clk(clk),
        .rst(rst),
        .keys(bus.keys_i),
        .voice_key(voice_key),
        .voice_active(voice_active)
    );

    always_comb begin
        state_n = state == IDLE   ? (bus.sample_tick_i ? ACCUM : IDLE) :
                  state == ACCUM  ? (vi == 2'(NUM_VOICES - 1) ? DIVIDE : ACCUM) :
                  state == DIVIDE ? DONE : IDLE;
        cur  = bus.samples_i[snap_key[vi*4 +: 4]*SAMPLE_W +: SAMPLE_W];
        prod = 20'(acc) * 20'(DIV3_MULT);
        avg  = cnt == 2'd0 ? '0 :
               cnt == 2'd1 ? acc[7:0] :
               cnt == 2'd2 ? acc[8:1] : 8'(prod >> DIV3_SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            snap_key  <= '0;
            snap_act  <= '0;
            vi        <= '0;
            cnt       <= '0;
            acc       <= '0;
            mixed_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state <= state_n;
            if (bus.sample_tick_i && state != IDLE) overrun_q <= 1'b1;
            if (state == IDLE && bus.sample_tick_i) begin
                snap_key <= voice_key;
                snap_act <= voice_active;
                vi       <= '0;
                cnt      <= '0;
                acc      <= '0;
            end
            if (state == ACCUM) begin
                vi <= vi + 2'd1;
                if (snap_act[vi]) begin
                    acc <= acc + 10'(cur);
                    cnt <= cnt + 2'd1;
                end
            end
            if (state == DIVIDE) mixed_q <= {avg, 4'b0000};
        end
    end

    assign bus.voice_key_o    = voice_key;
    assign bus.voice_active_o = voice_active;
    assign bus.mixed_sample_o = mixed_q;
    assign bus.mixed_valid_o  = state == DONE;
    assign bus.busy_o         = state != IDLE;
    assign bus.overrun_o      = overrun_q;
endmodule
